// File: rtl/run_launcher.sv
// Launch sequencer for the X9 core: loads a byte image, releases the core, times the run.
// Optional LAUNCH_CHKSUM_EN adds chk_sum, a modulo-2^DW sum of all accepted load bytes.
module run_launcher #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int CW         = 16,
   parameter int MAX_CYCLES = 4000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   input  logic          core_halt,
   output logic          core_reset,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_dat,
   output logic [CW-1:0] cycle_cnt,
   output logic          timeout,
`ifdef LAUNCH_CHKSUM_EN
   output logic [DW-1:0] chk_sum,
`endif
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAIN = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_CYCLES - 1);

   state_t state_q, state_d;
   logic   hs;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      ld_ready   = 1'b0;
      core_reset = 1'b1;
      done       = 1'b0;
      case (state_q)
         S_IDLE:  if (req) state_d = S_LOAD;
         S_LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid && ld_last) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_RUN;
         S_RUN: begin
            core_reset = 1'b0;
            if (core_halt || cycle_cnt == LAST_CNT) state_d = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (!req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign hs = ld_valid & ld_ready;

   // NOTE: registers use <= so each one samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_wr_en <= 1'b0;
         mem_addr  <= '0;
         mem_dat   <= '0;
         cycle_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         mem_wr_en <= hs;
         if (hs) begin
            mem_addr <= ld_addr;
            mem_dat  <= ld_data;
         end
         case (state_q)
            S_DRAIN: begin
               cycle_cnt <= '0;
               timeout   <= 1'b0;
            end
            // A halt cycle is not counted; the budget cycle is, so a timeout ends at MAX_CYCLES.
            S_RUN: begin
               if (!core_halt) begin
                  cycle_cnt <= cycle_cnt + CW'(1);
                  if (cycle_cnt == LAST_CNT) timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LAUNCH_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (reset)                      chk_sum <= '0;
      else if (state_q == S_IDLE && req) chk_sum <= '0;
      else if (hs)                    chk_sum <= chk_sum + ld_data;
   end
`endif

endmodule
